// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   op_e     : operation encodings presented on muldiv_unit.op
//   state_e  : controller states (IDLE, CALC, FIX)
//   ITER     : radix-2 iterations per multiply/divide
//   CNT_W    : width of the iteration counter
//   CNT_LAST : counter value of the final CALC iteration
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational conditional two's-complement negation.
//   neg : 1 = output the negation of a, 0 = pass a through
//   a   : WIDTH-bit input value
//   y   : WIDTH-bit result
// Used both to form operand magnitudes and to restore result signs.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   start : operation request, qualifies op (ignored while busy)
//   op    : MULT/MULTU/DIV/DIVU/MTHI/MTLO (6,7 ignored)
//   rs    : multiplicand / dividend / MTHI-MTLO source
//   rt    : multiplier / divisor
//   busy  : an operation is in progress
//   done  : one-cycle pulse when a multiply/divide updates hi/lo
//   hi,lo : architectural HI/LO registers
// Multiply and divide take 33 cycles: 32 radix-2 iterations then a sign
// fix-up/write-back cycle. Moves to HI/LO complete in the accepting edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;      // product, or {remainder, quotient}
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_res;  // negate product / quotient in FIX
  logic               neg_rem;  // negate remainder in FIX

  logic signed [WIDTH-1:0] rs_sgn, rt_sgn;
  logic             arith_op, signed_op, div_op, div_zero, accept;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign rs_sgn = rs;
  assign rt_sgn = rt;

  assign arith_op  = (op == OP_MULT) || (op == OP_MULTU) ||
                     (op == OP_DIV)  || (op == OP_DIVU);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign div_op    = (op == OP_DIV)  || (op == OP_DIVU);
  assign div_zero  = div_op && (rt == '0);
  assign accept    = start && (state == IDLE);

  // Divide-by-zero runs the raw dividend through the divider with no sign
  // handling: subtracting a zero divisor never borrows, so the quotient
  // comes out all ones and the remainder equals rs exactly.
  assign rs_neg = signed_op && (rs_sgn < 0) && !div_zero;
  assign rt_neg = signed_op && (rt_sgn < 0);

  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_rs (.neg(rs_neg), .a(rs), .y(rs_mag));
  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_rt (.neg(rt_neg), .a(rt), .y(rt_mag));

  // One radix-2 step of each algorithm
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: bring the next dividend bit into the remainder and
  // keep the difference only when it did not borrow.
  assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign div_next = div_diff[WIDTH]
                  ? {div_sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign fix-up of the finished result
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  muldiv_signfix #(.WIDTH(WIDTH))   u_fix_q (.neg(neg_res), .a(acc[WIDTH-1:0]),       .y(quot_fix));
  muldiv_signfix #(.WIDTH(WIDTH))   u_fix_r (.neg(neg_rem), .a(acc[2*WIDTH-1:WIDTH]), .y(rem_fix));
  muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_p (.neg(neg_res), .a(acc),                  .y(prod_fix));

  // Controller
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && arith_op) state_nxt = CALC;
      CALC:    if (cnt == CNT_LAST)    state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state != IDLE);

  // Datapath and architectural registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && arith_op) begin
            cnt     <= '0;
            is_div  <= div_op;
            acc     <= {{WIDTH{1'b0}}, (div_op ? rs_mag : rt_mag)};
            opnd    <= div_op ? rt_mag : rs_mag;
            neg_res <= signed_op && ((rs_sgn < 0) != (rt_sgn < 0)) && !div_zero;
            neg_rem <= signed_op && div_op && (rs_sgn < 0) && !div_zero;
          end else if (accept && (op == OP_MTHI)) begin
            hi <= rs;
          end else if (accept && (op == OP_MTLO)) begin
            lo <= rs;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mhi = '0;  // expected architectural HI
  logic [31:0] mlo = '0;  // expected architectural LO

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: MIPS HI/LO semantics from plain 64-bit arithmetic
  function automatic void model(input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, pu;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    rh = '0;
    rl = '0;
    case (o)
      3'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin pu = ua * ub; rh = pu[63:32]; rl = pu[31:0]; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          rh = a; rl = 32'hFFFF_FFFF;
        end else if (o == 3'd2) begin
          q = sa / sb; r = sa % sb; rh = r[31:0]; rl = q[31:0];
        end else begin
          rh = a % b; rl = a / b;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue one multiply/divide and follow it to its done cycle; returns in
  // the done cycle so a following call starts there (back-to-back).
  task automatic run_arith(input string name, input logic [2:0] o,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    bit dmid;
    start = 1'b1; op = o; rs = a; rt = b;
    step();
    start = 1'b0; rs = $urandom; rt = $urandom;
    n = 0;
    dmid = 0;
    while (busy && n < 40) begin
      if (done) dmid = 1;
      if (n == 16) begin
        vectors++;
        if (hi !== mhi || lo !== mlo) begin
          miscompares++;
          $display("FAIL %s mid-op hi/lo: got %h/%h want %h/%h", name, hi, lo, mhi, mlo);
        end
      end
      step();
      n++;
    end
    vectors++;
    if (n != 33) begin
      miscompares++;
      $display("FAIL %s busy cycles: got %0d want 33", name, n);
    end
    vectors++;
    if (done !== 1'b1 || dmid) begin
      miscompares++;
      $display("FAIL %s done pulse: got done=%b early=%0d want done=1 early=0", name, done, dmid);
    end
    vectors++;
    if (hi !== ehi || lo !== elo) begin
      miscompares++;
      $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, ehi, elo);
    end
    mhi = ehi;
    mlo = elo;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
    step();
    step();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h want 0/0/0/0", busy, done, hi, lo);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_mult_signed();
    run_arith("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
  endtask

  task automatic test_mult_unsigned();
    run_arith("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
  endtask

  task automatic test_div_signed();
    run_arith("div_neg7by2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
  endtask

  task automatic test_div_unsigned();
    run_arith("divu_7by2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3);
  endtask

  task automatic test_div_corners();
    run_arith("div_by_zero", 3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_arith("div_neg_by_zero", 3'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_arith("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
  endtask

  task automatic test_moves();
    start = 1'b1; op = 3'd5; rs = 32'h0000_1234;
    step();
    start = 1'b0;
    mlo = 32'h0000_1234;
    vectors++;
    if (lo !== mlo || hi !== mhi || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b want hi=%h lo=%h busy=0 done=0",
               hi, lo, busy, done, mhi, mlo);
    end
    start = 1'b1; op = 3'd4; rs = 32'hCAFE_0001;
    step();
    start = 1'b0;
    mhi = 32'hCAFE_0001;
    vectors++;
    if (hi !== mhi || lo !== mlo || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi: got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0", hi, lo, busy, mhi, mlo);
    end
    start = 1'b1; op = 3'd6; rs = 32'hDEAD_BEEF;
    step();
    start = 1'b0;
    step();
    vectors++;
    if (hi !== mhi || lo !== mlo || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL op6_ignored: got hi=%h lo=%h busy=%b done=%b want hi=%h lo=%h 0 0",
               hi, lo, busy, done, mhi, mlo);
    end
  endtask

  task automatic test_hazard_mthi();
    int n;
    start = 1'b1; op = 3'd1; rs = 32'd3; rt = 32'd5;
    step();
    start = 1'b0; op = 3'd4; rs = 32'h0000_AAAA;
    n = 0;
    while (busy && n < 40) begin
      start = (n == 4);
      step();
      n++;
    end
    start = 1'b0;
    vectors++;
    if (n != 33 || done !== 1'b1 || hi !== 32'd0 || lo !== 32'd15) begin
      miscompares++;
      $display("FAIL hazard_mthi: got cycles=%0d done=%b hi=%h lo=%h want 33 1 0 f", n, done, hi, lo);
    end
    mhi = 32'd0;
    mlo = 32'd15;
    step();
    vectors++;
    if (hi !== mhi || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hazard_after: got hi=%h busy=%b want hi=%h busy=0", hi, busy, mhi);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    start = 1'b1; op = 3'd4; rs = 32'h5555_5555;
    step();
    op = 3'd5; rs = 32'h3333_3333;
    step();
    start = 1'b1; op = 3'd3; rs = 32'd1000; rt = 32'd7;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    mhi = '0;
    mlo = '0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want 0/0/0/0", busy, done, hi, lo);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) pulses++;
      step();
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: got %0d busy/done cycles want 0", pulses);
    end
    run_arith("after_reset", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);
  endtask

  task automatic test_back_to_back();
    run_arith("b2b_first", 3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    run_arith("b2b_second", 3'd3, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF);
    step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done_width: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b, eh, el;
    for (int k = 0; k < 30; k++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 9));
        1: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      if (o <= 3'd3) begin
        model(o, a, b, eh, el);
        run_arith("random_arith", o, a, b, eh, el);
      end else begin
        start = 1'b1; op = o; rs = a; rt = b;
        step();
        start = 1'b0;
        if (o == 3'd4) mhi = a;
        if (o == 3'd5) mlo = a;
        vectors++;
        if (hi !== mhi || lo !== mlo || busy !== 1'b0 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL random_move op=%0d: got hi=%h lo=%h busy=%b done=%b want hi=%h lo=%h 0 0",
                   o, hi, lo, busy, done, mhi, mlo);
        end
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_mult_unsigned();
    test_div_signed();
    test_div_unsigned();
    test_div_corners();
    test_moves();
    test_hazard_mthi();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath execute stage. Consumes busA/busB operands alongside the ALU for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Produces HI/LO values that the write-back mux selects onto busW for MFHI/MFLO. Uses a start/busy/done handshake so the control unit can stall the pipeline while an operation is running.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is required to be supported.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the unit.
- start  in  1  request, sampled at the rising edge; qualifies op.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are ignored.
- rs  in  WIDTH  busA operand: multiplicand, dividend, or MTHI/MTLO source.
- rt  in  WIDTH  busB operand: multiplier or divisor.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- hi, lo  out  WIDTH  architectural HI/LO registers, read directly by MFHI/MFLO.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE + start + op 0-3:**
  - Latch operand magnitudes.
  - Signed ops take the absolute value of rs and rt; result signs are held in registers.
  - Clear the 5-bit iteration counter and go to CALC.
- **IDLE + start + op 4/5:** write rs into hi or lo at that same edge. State stays IDLE; busy and done stay 0.
- **CALC:**
  - One radix-2 iteration per edge.
  - Multiply: shift-add over a 2·WIDTH product register.
  - Divide: restoring shift-subtract; the remainder goes to the upper half, the quotient to the lower half.
  - After 32 iterations go to FIX.
- **FIX, signed multiply:** negate the 64-bit product if the operand signs differ.
- **FIX, signed divide:**
  - Quotient is negative if the operand signs differ.
  - Remainder takes the sign of the dividend.
- **FIX, write-back:** write hi/lo, set done for one cycle, return to IDLE.
- **Divide by zero (rt==0, detected at start):**
  - Same latency as any divide.
  - Result is lo=32'hFFFFFFFF and hi=rs, with no sign fix-up, for both DIV and DIVU.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives lo=0x80000000 and hi=0 (wraps; no exception).
- start while busy: ignored, including MTHI/MTLO. The control unit must stall the pipeline.
- hi/lo keep their old values until FIX; MFHI issued mid-operation reads the old value.
- **Reset (any state, including mid-operation):**
  - State goes to IDLE.
  - hi, lo and all datapath registers go to 0.
  - busy and done go to 0.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0.
- busy = (state != IDLE); it is a registered-state decode with no combinational path from start.
- Sequence for a start accepted at edge E0:
  - busy=1 from after E0.
  - CALC iterations occur at E1..E32.
  - FIX occurs at E33.
  - hi/lo are valid and done=1 from after E33 for exactly one cycle; busy=0 in that same cycle.
- Latency from accepted start to valid hi/lo is 33 cycles. A new start is accepted at E33+1, i.e. in the done cycle.
- MTHI/MTLO latency is 1 edge.

## Structure
- Package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO;
  - the state enum: IDLE, CALC, FIX;
  - ITER=32 and the counter width.
- Sub-module muldiv_signfix: combinational conditional two's-complement negation, WIDTH parameter. It is instantiated for operand absolute values, the quotient/remainder fix-up, and the 64-bit product.
- All remaining logic is one FSM plus datapath in muldiv_unit.

## Test plan
- **Signed multiply:** MULT rs=0xFFFFFFFD (-3), rt=7 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB. done high for exactly one cycle; busy high for 33 cycles.
- **Unsigned multiply:** MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- **Signed divide:** DIV rs=-7 (0xFFFFFFF9), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **Unsigned divide:** DIVU 7/2 → lo=3, hi=1.
- **Divide corner cases:**
  - DIV rs=5, rt=0 → lo=0xFFFFFFFF, hi=5, with the same 33-cycle latency.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- **Moves:** MTLO rs=0x1234 in IDLE → lo=0x1234 after one edge, busy stays 0, done stays 0, hi unchanged.
- **Hazards:**
  - Start MULTU 3×5, then MTHI 0xAAAA at cycle 5 → MTHI is ignored; final hi=0, lo=15.
  - A second run with reset=0 at cycle 10 → busy=0, hi=lo=0, done never pulses; start is accepted on the next edge after reset=1.
